// File: rtl/i2c_eeprom_gen_if.sv
// Bus bundle between the I2C slave front end and the EEPROM emulation core:
// addressed flag, write/read byte streams, and slave control outputs.
interface i2c_eeprom_gen_if;
   logic       addressed;
   logic [7:0] m_tdata;
   logic       m_tvalid;
   logic       m_tlast;
   logic       m_tready;
   logic [7:0] s_tdata;
   logic       s_tvalid;
   logic       s_tlast;
   logic       s_tready;
   logic       slave_enable;
   logic       release_bus;
   logic       busy;

   modport slave (
      input  addressed, m_tdata, m_tvalid, m_tlast, s_tready,
      output m_tready, s_tdata, s_tvalid, s_tlast, slave_enable, release_bus, busy
   );

   modport master (
      output addressed, m_tdata, m_tvalid, m_tlast, s_tready,
      input  m_tready, s_tdata, s_tvalid, s_tlast, slave_enable, release_bus, busy
   );
endinterface

// File: rtl/i2c_eeprom_gen.sv
// I2C EEPROM emulation core: word-address load, page writes, sequential reads,
// timed write cycle. Define I2C_EEPROM_WP_EN to add the wp write-protect input.
module i2c_eeprom_gen #(
   parameter int MEM_BYTES  = 2048,
   parameter int ADDR_BYTES = 2,
   parameter int PAGE_BYTES = 16,
   parameter int WR_CYCLES  = 1000
) (
   input  logic clk,
   input  logic rst,
`ifdef I2C_EEPROM_WP_EN
   input  logic wp,
`endif
   i2c_eeprom_gen_if.slave bus
);

   localparam int AW = $clog2(MEM_BYTES);
   localparam int TW = (WR_CYCLES > 1) ? $clog2(WR_CYCLES) : 1;

   typedef logic [AW-1:0] ptr_t;
   typedef enum logic [2:0] {IDLE, ADDR, WRITE, READ, WCYC} state_t;

   localparam ptr_t        PAGE_MASK = ptr_t'(PAGE_BYTES - 1);
   localparam logic [1:0]  LAST_ADDR = 2'(ADDR_BYTES - 1);
   localparam logic [TW-1:0] LAST_T  = TW'(WR_CYCLES - 1);

   state_t        state_q, state_d;
   ptr_t          ptr_q, ptr_d;
   logic [1:0]    cnt_q, cnt_d;
   logic          wrote_q, wrote_d;
   logic [TW-1:0] timer_q, timer_d;
   logic          addressed_q;
   logic          release_q, release_d;
   logic          mem_we;
   logic [7:0]    mem_q [MEM_BYTES];

   logic wp_on;
`ifdef I2C_EEPROM_WP_EN
   assign wp_on = wp;
`else
   assign wp_on = 1'b0;
`endif

   logic rise, fall, m_beat, end_evt;
   assign rise    = bus.addressed & ~addressed_q;
   assign fall    = ~bus.addressed & addressed_q;
   assign m_beat  = bus.m_tvalid & bus.m_tready;
   // A last-flagged write beat closes the transaction exactly like a STOP.
   assign end_evt = fall | (m_beat & bus.m_tlast);

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      cnt_d     = cnt_q;
      wrote_d   = wrote_q;
      timer_d   = timer_q;
      release_d = 1'b0;
      mem_we    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (rise) begin
               state_d = ADDR;
               cnt_d   = '0;
            end
         end
         ADDR: begin
            if (m_beat) begin
               ptr_d = ptr_t'({(cnt_q == '0) ? 8'h00 : ptr_q[7:0], bus.m_tdata});
               if (cnt_q == LAST_ADDR) begin
                  state_d = WRITE;
                  wrote_d = 1'b0;
               end else begin
                  cnt_d = cnt_q + 2'd1;
               end
            end else if (bus.s_tready && cnt_q == '0) begin
               state_d = READ;
            end
            if (end_evt) begin
               state_d   = IDLE;
               release_d = 1'b1;
            end
         end
         WRITE: begin
            if (m_beat) begin
               mem_we  = ~wp_on;
               ptr_d   = (ptr_q & ~PAGE_MASK) | (ptr_t'(ptr_q + 1'b1) & PAGE_MASK);
               wrote_d = 1'b1;
            end else if (bus.s_tready) begin
               state_d = READ;
            end
            if (end_evt) begin
               release_d = 1'b1;
               timer_d   = '0;
               state_d   = ((wrote_q | m_beat) & ~wp_on) ? WCYC : IDLE;
            end
         end
         READ: begin
            if (bus.s_tready) ptr_d = ptr_t'(ptr_q + 1'b1);
            if (end_evt) begin
               state_d   = IDLE;
               release_d = 1'b1;
            end
         end
         WCYC: begin
            if (timer_q == LAST_T) begin
               state_d = IDLE;
               timer_d = '0;
            end else begin
               timer_d = timer_q + TW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         ptr_q       <= '0;
         cnt_q       <= '0;
         wrote_q     <= 1'b0;
         timer_q     <= '0;
         addressed_q <= 1'b0;
         release_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         cnt_q       <= cnt_d;
         wrote_q     <= wrote_d;
         timer_q     <= timer_d;
         addressed_q <= bus.addressed;
         release_q   <= release_d;
      end
   end

   // NOTE: storage has no reset so contents survive rst and map onto plain RAM.
   always_ff @(posedge clk) begin
      if (mem_we) mem_q[ptr_q] <= bus.m_tdata;
   end

   assign bus.m_tready     = (state_q == ADDR) || (state_q == WRITE);
   assign bus.s_tvalid     = (state_q == READ);
   assign bus.s_tdata      = mem_q[ptr_q];
   assign bus.s_tlast      = 1'b0;
   assign bus.busy         = (state_q == WCYC);
   assign bus.slave_enable = (state_q != WCYC);
   assign bus.release_bus  = release_q;

endmodule

// File: tb/tb_i2c_eeprom_gen.sv
// Self-checking bench for i2c_eeprom_gen: directed scenarios plus random
// write/read-back traffic checked against an array-based EEPROM model.
module tb_i2c_eeprom_gen;
   localparam int MEM  = 2048;
   localparam int PAGE = 16;
   localparam int WR   = 1000;

   logic clk = 1'b0;
   logic rst = 1'b1;
`ifdef I2C_EEPROM_WP_EN
   logic wp = 1'b0;
`endif
   i2c_eeprom_gen_if bus_if ();

   i2c_eeprom_gen dut (
      .clk (clk),
      .rst (rst),
`ifdef I2C_EEPROM_WP_EN
      .wp  (wp),
`endif
      .bus (bus_if)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   logic [7:0] ref_mem [MEM];
   bit         ref_ok  [MEM];
   int         ref_ptr = 0;
   bit         wp_cur  = 1'b0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] d, input bit last);
      bus_if.m_tdata  = d;
      bus_if.m_tvalid = 1'b1;
      bus_if.m_tlast  = last;
      check("m_tready_accept", bus_if.m_tready, 1);
      tick();
      bus_if.m_tvalid = 1'b0;
      bus_if.m_tlast  = 1'b0;
   endtask

   // Full write transaction; the model applies page wrap and write protect.
   task automatic do_write(input int addr, input logic [7:0] data[$], input bit use_last);
      int p;
      logic [15:0] a16;
      a16 = 16'(addr);
      bus_if.addressed = 1'b1;
      tick();
      send(a16[15:8], 1'b0);
      send(a16[7:0], 1'b0);
      p = addr % MEM;
      foreach (data[i]) begin
         send(data[i], use_last && (i == data.size() - 1));
         if (!wp_cur) begin
            ref_mem[p] = data[i];
            ref_ok[p]  = 1'b1;
         end
         p = (p / PAGE) * PAGE + (p + 1) % PAGE;
      end
      ref_ptr = p;
      bus_if.addressed = 1'b0;
      if (!use_last || data.size() == 0) tick();
   endtask

   task automatic wait_wcyc(input string tag, input int exp);
      int n = 0;
      int sen = 0;
      check({tag, "_release"}, bus_if.release_bus, 1);
      while (bus_if.busy === 1'b1 && n < WR + 100) begin
         n++;
         if (bus_if.slave_enable === 1'b0) sen++;
         tick();
      end
      check({tag, "_busy_cycles"}, n, exp);
      check({tag, "_sen_low_cycles"}, sen, exp);
      check({tag, "_sen_after"}, bus_if.slave_enable, 1);
   endtask

   task automatic do_read(input string tag, input int n, input bit random, input int addr);
      logic [15:0] a16;
      a16 = 16'(addr);
      bus_if.addressed = 1'b1;
      tick();
      if (random) begin
         send(a16[15:8], 1'b0);
         send(a16[7:0], 1'b0);
         ref_ptr = addr % MEM;
      end
      bus_if.s_tready = 1'b1;
      tick();
      for (int i = 0; i < n; i++) begin
         check({tag, "_s_tvalid"}, bus_if.s_tvalid, 1);
         check({tag, "_s_tlast"}, bus_if.s_tlast, 0);
         if (ref_ok[ref_ptr]) check({tag, "_data"}, bus_if.s_tdata, ref_mem[ref_ptr]);
         tick();
         ref_ptr = (ref_ptr + 1) % MEM;
      end
      bus_if.s_tready  = 1'b0;
      bus_if.addressed = 1'b0;
      tick();
      check({tag, "_release"}, bus_if.release_bus, 1);
      check({tag, "_no_wcyc"}, bus_if.busy, 0);
      tick();
      check({tag, "_release_1cyc"}, bus_if.release_bus, 0);
      check({tag, "_idle_sen"}, bus_if.slave_enable, 1);
   endtask

   initial begin
      #500_000;
      $display("FAIL watchdog: simulation did not finish, total=%0d", total);
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [7:0] q[$];
      int addr, len;
      bit use_last;

      bus_if.addressed = 1'b0;
      bus_if.m_tdata   = 8'h00;
      bus_if.m_tvalid  = 1'b0;
      bus_if.m_tlast   = 1'b0;
      bus_if.s_tready  = 1'b0;
      #12;
      check("rst_m_tready", bus_if.m_tready, 0);
      check("rst_s_tvalid", bus_if.s_tvalid, 0);
      check("rst_release", bus_if.release_bus, 0);
      check("rst_busy", bus_if.busy, 0);
      check("rst_sen", bus_if.slave_enable, 1);
      tick();
      rst = 1'b0;
      tick();

      // Basic two-byte write and read-back.
      q = '{8'hAA, 8'hBB};
      do_write(16'h0123, q, 1'b0);
      wait_wcyc("wr123", WR);
      do_read("rd123", 2, 1'b1, 16'h0123);

      // 18-byte page write wrapping inside the 16-byte page at 0x000.
      q.delete();
      for (int i = 0; i < 18; i++) q.push_back(8'(i));
      do_write(16'h000E, q, 1'b1);
      wait_wcyc("page", WR);
      do_read("rd_page", 16, 1'b1, 16'h0000);

      // Seed the top byte, then random read across the memory wrap.
      q = '{8'($urandom_range(0, 255))};
      do_write(16'h07FF, q, 1'b0);
      wait_wcyc("wr7ff", WR);
      do_read("rd7ff", 3, 1'b1, 16'h07FF);
      do_read("cur_rd", 1, 1'b0, 0);

      // Write beats offered while idle must be ignored.
      bus_if.m_tvalid = 1'b1;
      bus_if.m_tdata  = 8'hEE;
      for (int i = 0; i < 3; i++) begin
         check("idle_m_tready", bus_if.m_tready, 0);
         tick();
      end
      bus_if.m_tvalid = 1'b0;
      do_read("cur_rd2", 1, 1'b0, 0);

      // Address-only write: no write cycle.
      q.delete();
      do_write(16'h0345, q, 1'b0);
      wait_wcyc("zero_data", 0);

      // Reset in the middle of a write cycle.
      q = '{8'h3C};
      do_write(16'h0200, q, 1'b0);
      repeat (100) tick();
      check("mid_wcyc_busy", bus_if.busy, 1);
      rst = 1'b1;
      #1;
      check("rst_wcyc_busy", bus_if.busy, 0);
      check("rst_wcyc_sen", bus_if.slave_enable, 1);
      check("rst_wcyc_m_tready", bus_if.m_tready, 0);
      tick();
      rst = 1'b0;
      ref_ptr = 0;
      tick();
      do_read("post_rst_cur", 1, 1'b0, 0);
      do_read("post_rst_rd", 1, 1'b1, 16'h0200);

`ifdef I2C_EEPROM_WP_EN
      q = '{8'h99};
      do_write(16'h0010, q, 1'b0);
      wait_wcyc("wp_seed", WR);
      wp = 1'b1;
      wp_cur = 1'b1;
      q = '{8'h55};
      do_write(16'h0010, q, 1'b0);
      wait_wcyc("wp_on", 0);
      wp = 1'b0;
      wp_cur = 1'b0;
      do_read("wp_rd", 1, 1'b1, 16'h0010);
`endif

      // Random write/read-back traffic, including discarded upper address bits.
      for (int t = 0; t < 5; t++) begin
         addr     = int'($urandom_range(0, 65535));
         len      = int'($urandom_range(1, 20));
         use_last = 1'($urandom_range(0, 1));
         q.delete();
         for (int i = 0; i < len; i++) q.push_back(8'($urandom_range(0, 255)));
         do_write(addr, q, use_last);
         wait_wcyc("rnd_wr", WR);
         do_read("rnd_rd", len, 1'b1, addr);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/i2c_eeprom_gen.md
I2C_EEPROM_GEN -- requirements
Module: i2c_eeprom_gen

Interface
REQ-001 SHALL have parameter MEM_BYTES, default 2048, memory size in bytes (power of two, 256..65536).
REQ-002 SHALL have parameter ADDR_BYTES, default 2, number of word-address bytes sent after the device address (1 or 2).
REQ-003 SHALL have parameter PAGE_BYTES, default 16, page-write wrap size (power of two, not greater than MEM_BYTES).
REQ-004 SHALL have parameter WR_CYCLES, default 1000, internal write-cycle time in clk cycles (at least 1).
REQ-005 SHALL have one clock and an asynchronous, active-high reset.
REQ-006 SHALL have port clk, input, 1 bit: clock.
REQ-007 SHALL have port rst, input, 1 bit: asynchronous active-high reset.
REQ-008 SHALL have port addressed, input, 1 bit: high from the address ACK of the I2C slave until STOP or repeated START.
REQ-009 SHALL have port m_tdata/m_tvalid/m_tlast, input, 8/1/1 bits: bytes written by the bus master.
REQ-010 SHALL have port m_tready, output, 1 bit: write-byte accept.
REQ-011 SHALL have port s_tdata/s_tvalid/s_tlast, output, 8/1/1 bits: bytes returned to the bus master on reads.
REQ-012 SHALL have port s_tready, input, 1 bit: read-byte consume.
REQ-013 SHALL have port slave_enable, output, 1 bit: drives the I2C slave enable; when low, the device address is NACKed.
REQ-014 SHALL have port release_bus, output, 1 bit: one-cycle release request to the I2C slave.
REQ-015 SHALL have port busy, output, 1 bit: write cycle in progress.

Function
REQ-016 SHALL use states IDLE, ADDR, WRITE, READ, WCYC.
REQ-017 IDLE: rising edge of addressed SHALL go to ADDR with byte counter 0.
REQ-018 ADDR: an m beat SHALL load the next address byte (MSB first); after ADDR_BYTES beats, SHALL go to WRITE.
REQ-019 ADDR: s_tready before any m beat SHALL go to READ without changing the pointer (current-address read).
REQ-020 Pointer width SHALL be log2(MEM_BYTES); unused upper address bits SHALL be discarded.
REQ-021 m_tready SHALL be 1 in ADDR and WRITE, and 0 elsewhere.
REQ-022 WRITE: each m beat SHALL write memory at the pointer in the same cycle.
REQ-023 WRITE: after each m beat, the pointer SHALL advance by 1, wrapping within the PAGE_BYTES-aligned page; upper bits SHALL be unchanged.
REQ-024 READ: s_tvalid SHALL be 1 and s_tdata SHALL be the memory contents at the pointer (combinational).
REQ-025 READ: each s beat SHALL advance the pointer by 1, wrapping from MEM_BYTES-1 to 0.
REQ-026 READ: s_tlast SHALL be 0.
REQ-027 WRITE: s_tready SHALL go to READ (repeated START random read); the pointer SHALL keep the loaded address.
REQ-028 Falling edge of addressed in ADDR or READ SHALL pulse release_bus for one cycle and go to IDLE.
REQ-029 Falling edge of addressed in WRITE with at least one data byte written SHALL pulse release_bus and go to WCYC.
REQ-030 Falling edge of addressed in WRITE with zero data bytes SHALL pulse release_bus and go to IDLE.
REQ-031 An m beat with m_tlast SHALL be treated as end of transaction, identically to a falling edge of addressed in the same cycle.
REQ-032 WCYC: busy SHALL be 1 and slave_enable SHALL be 0 for exactly WR_CYCLES cycles, then SHALL go to IDLE.
REQ-033 Outside WCYC, slave_enable SHALL be 1 and busy SHALL be 0.
REQ-034 m beats arriving in IDLE, READ or WCYC SHALL be ignored.

Reset
REQ-035 rst SHALL asynchronously force state IDLE, pointer 0, byte counter 0, write-cycle timer 0, and outputs m_tready=0, s_tvalid=0, release_bus=0, busy=0, slave_enable=1.
REQ-036 Reset during WRITE or WCYC SHALL abort the operation; bytes already written SHALL remain, and memory contents SHALL NOT be reset.

Configuration
REQ-037 With I2C_EEPROM_WP_EN defined, the block SHALL have input wp (1 bit); while wp=1, WRITE beats SHALL be accepted and SHALL advance the pointer but SHALL NOT modify memory, and the transaction SHALL go to IDLE, not WCYC.
REQ-038 Without I2C_EEPROM_WP_EN, the wp port SHALL be absent and all writes SHALL be enabled.

Verification
REQ-039 Bench SHALL apply (defaults) address bytes 0x01,0x23, data 0xAA,0xBB, end -> mem[0x123]=0xAA, mem[0x124]=0xBB, busy high 1000 cycles, slave_enable low for the same 1000 cycles.
REQ-040 Bench SHALL apply a page write of 18 bytes (values 0..17) at 0x00E -> wrap within the 16-byte page; mem[0x00E]=16, mem[0x00F]=17, mem[0x000]=2.
REQ-041 Bench SHALL apply address 0x7FF, then repeated START and 3 reads -> data returned from mem[0x7FF], mem[0x000], mem[0x001]; no WCYC.
REQ-042 Bench SHALL apply a current-address read after REQ-041 -> returns mem[0x002].
REQ-043 Bench SHALL assert rst mid-WCYC -> busy=0 and slave_enable=1 immediately; next transaction accepted.
REQ-044 Bench SHALL apply, with I2C_EEPROM_WP_EN and wp=1, a write of 0x55 to 0x010 -> mem unchanged, busy stays 0.
